// File: rtl/branch_pkg.sv
// Shared definitions for the dynamic branch predictor.
//   NUM_ENTRIES : number of direct-mapped BHT/BTB entries
//   INDEX_W     : index width, taken from PC[3:1]
//   TAG_W       : tag width, taken from PC[15:4]
//   PC_W        : program counter width
//   ctr_e       : 2-bit saturating direction counter encoding
package branch_pkg;

    localparam int NUM_ENTRIES = 8;
    localparam int INDEX_W     = 3;
    localparam int TAG_W       = 12;
    localparam int PC_W        = 16;

    typedef enum logic [1:0] {
        SNT = 2'b00,   // strongly not taken
        WNT = 2'b01,   // weakly not taken
        WT  = 2'b10,   // weakly taken
        ST  = 2'b11    // strongly taken
    } ctr_e;

endpackage

// File: rtl/sat_counter_2b.sv
// Two-bit saturating direction counter, one per BHT entry.
//   clk, rst_n : clock and asynchronous active-low reset (resets to WNT)
//   en_i       : update strobe for this entry
//   alloc_i    : entry is being (re)allocated; load from taken_i instead of counting
//   taken_i    : resolved direction
//   ctr_o      : current counter state
module sat_counter_2b
    import branch_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic en_i,
    input  logic alloc_i,
    input  logic taken_i,
    output ctr_e ctr_o
);

    ctr_e ctr_q;
    ctr_e ctr_d;

    always_comb begin
        ctr_d = ctr_q;
        if (en_i) begin
            if (alloc_i) begin
                // A freshly allocated entry starts weakly biased toward the outcome.
                ctr_d = taken_i ? WT : WNT;
            end else if (taken_i) begin
                if (ctr_q != ST) ctr_d = ctr_e'(ctr_q + 2'd1);
            end else begin
                if (ctr_q != SNT) ctr_d = ctr_e'(ctr_q - 2'd1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ctr_q <= WNT;
        else        ctr_q <= ctr_d;
    end

    assign ctr_o = ctr_q;

endmodule

// File: rtl/dynamic_branch_predictor.sv
// Direct-mapped branch history table plus branch target buffer.
// Prediction is a purely combinational lookup on PC_curr; updates from the
// decode stage are written on the rising edge, so a same-cycle read of the
// entry being updated sees the old contents.
//   clk, rst_n        : clock, asynchronous active-low reset
//   PC_curr           : fetch PC being predicted
//   IF_ID_PC_curr     : PC of the branch resolved in decode (update address)
//   wen_BHT           : direction update strobe, with actual_taken
//   wen_BTB           : target update strobe, with actual_target
//   predicted_taken   : BHT hit, counter taken-biased, and BTB hit
//   predicted_target  : BTB target on BTB hit, else PC_curr + 2
module dynamic_branch_predictor
    import branch_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic [PC_W-1:0] PC_curr,
    input  logic [PC_W-1:0] IF_ID_PC_curr,
    input  logic            wen_BHT,
    input  logic            actual_taken,
    input  logic            wen_BTB,
    input  logic [PC_W-1:0] actual_target,
    output logic            predicted_taken,
    output logic [PC_W-1:0] predicted_target
);

    logic [INDEX_W-1:0] rd_idx;
    logic [TAG_W-1:0]   rd_tag;
    logic [INDEX_W-1:0] upd_idx;
    logic [TAG_W-1:0]   upd_tag;
    logic               unused_upd_pc_lsb;

    // PC[0] carries no information for halfword-aligned instructions.
    assign rd_idx            = PC_curr[INDEX_W:1];
    assign rd_tag            = PC_curr[PC_W-1:INDEX_W+1];
    assign upd_idx           = IF_ID_PC_curr[INDEX_W:1];
    assign upd_tag           = IF_ID_PC_curr[PC_W-1:INDEX_W+1];
    assign unused_upd_pc_lsb = IF_ID_PC_curr[0];

    // BHT storage
    logic [NUM_ENTRIES-1:0] bht_valid_q;
    logic [TAG_W-1:0]       bht_tag_q [NUM_ENTRIES];
    ctr_e                   bht_ctr   [NUM_ENTRIES];

    // BTB storage
    logic [NUM_ENTRIES-1:0] btb_valid_q;
    logic [TAG_W-1:0]       btb_tag_q    [NUM_ENTRIES];
    logic [PC_W-1:0]        btb_target_q [NUM_ENTRIES];

    logic upd_bht_hit;
    assign upd_bht_hit = bht_valid_q[upd_idx] && (bht_tag_q[upd_idx] == upd_tag);

    for (genvar i = 0; i < NUM_ENTRIES; i++) begin : g_ctr
        sat_counter_2b u_ctr (
            .clk     (clk),
            .rst_n   (rst_n),
            .en_i    (wen_BHT && (upd_idx == INDEX_W'(i))),
            .alloc_i (!upd_bht_hit),
            .taken_i (actual_taken),
            .ctr_o   (bht_ctr[i])
        );
    end

    // A miss replaces whatever lived at this index (no associativity).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bht_valid_q <= '0;
            for (int i = 0; i < NUM_ENTRIES; i++) bht_tag_q[i] <= '0;
        end else if (wen_BHT && !upd_bht_hit) begin
            bht_valid_q[upd_idx] <= 1'b1;
            bht_tag_q[upd_idx]   <= upd_tag;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btb_valid_q <= '0;
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                btb_tag_q[i]    <= '0;
                btb_target_q[i] <= '0;
            end
        end else if (wen_BTB) begin
            btb_valid_q[upd_idx]  <= 1'b1;
            btb_tag_q[upd_idx]    <= upd_tag;
            btb_target_q[upd_idx] <= actual_target;
        end
    end

    // Zero-latency lookup
    logic rd_bht_hit;
    logic rd_btb_hit;
    logic rd_ctr_taken;

    assign rd_bht_hit   = bht_valid_q[rd_idx] && (bht_tag_q[rd_idx] == rd_tag);
    assign rd_btb_hit   = btb_valid_q[rd_idx] && (btb_tag_q[rd_idx] == rd_tag);
    assign rd_ctr_taken = (bht_ctr[rd_idx] == WT) || (bht_ctr[rd_idx] == ST);

    assign predicted_taken  = rd_bht_hit && rd_ctr_taken && rd_btb_hit;
    assign predicted_target = rd_btb_hit ? btb_target_q[rd_idx] : (PC_curr + 16'd2);

endmodule

// File: tb/tb_dynamic_branch_predictor.sv
module tb_dynamic_branch_predictor;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] PC_curr = '0;
    logic [15:0] IF_ID_PC_curr = '0;
    logic        wen_BHT = 1'b0;
    logic        actual_taken = 1'b0;
    logic        wen_BTB = 1'b0;
    logic [15:0] actual_target = '0;
    logic        predicted_taken;
    logic [15:0] predicted_target;

    dynamic_branch_predictor dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .PC_curr          (PC_curr),
        .IF_ID_PC_curr    (IF_ID_PC_curr),
        .wen_BHT          (wen_BHT),
        .actual_taken     (actual_taken),
        .wen_BTB          (wen_BTB),
        .actual_target    (actual_target),
        .predicted_taken  (predicted_taken),
        .predicted_target (predicted_target)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    bit cmp_en = 1'b0;

    // Behavioural model: per-index records, counters as plain integers 0..3.
    bit m_bht_v [8];
    int m_bht_tag [8];
    int m_ctr [8];
    bit m_btb_v [8];
    int m_btb_tag [8];
    int m_tgt [8];

    function automatic int idx_of(int pc);
        return (pc >> 1) % 8;
    endfunction

    function automatic int tag_of(int pc);
        return (pc >> 4) & 'hFFF;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 8; i++) begin
            m_bht_v[i] = 0; m_bht_tag[i] = 0; m_ctr[i] = 1;
            m_btb_v[i] = 0; m_btb_tag[i] = 0; m_tgt[i] = 0;
        end
    endfunction

    function automatic void model_predict(input int pc, output bit tk, output int tgt);
        int  i;
        bit  bh, bt;
        i  = idx_of(pc);
        bh = m_bht_v[i] && (m_bht_tag[i] == tag_of(pc));
        bt = m_btb_v[i] && (m_btb_tag[i] == tag_of(pc));
        tk  = bh && (m_ctr[i] >= 2) && bt;
        tgt = bt ? m_tgt[i] : ((pc + 2) % 65536);
    endfunction

    always @(negedge rst_n) model_reset();

    always @(posedge clk) begin
        if (rst_n) begin
            int i, t;
            i = idx_of(IF_ID_PC_curr);
            t = tag_of(IF_ID_PC_curr);
            if (wen_BHT) begin
                if (m_bht_v[i] && m_bht_tag[i] == t) begin
                    if (actual_taken) m_ctr[i] = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
                    else              m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
                end else begin
                    m_bht_v[i] = 1; m_bht_tag[i] = t; m_ctr[i] = actual_taken ? 2 : 1;
                end
            end
            if (wen_BTB) begin
                m_btb_v[i] = 1; m_btb_tag[i] = t; m_tgt[i] = actual_target;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            bit tk;
            int tg;
            model_predict(PC_curr, tk, tg);
            check("model_taken", {31'd0, predicted_taken}, {31'd0, tk});
            check("model_target", {16'd0, predicted_target}, tg);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [15:0] pc, input logic [15:0] upc, input logic wb,
                         input logic tk, input logic wt, input logic [15:0] tg);
        PC_curr = pc; IF_ID_PC_curr = upc; wen_BHT = wb;
        actual_taken = tk; wen_BTB = wt; actual_target = tg;
    endtask

    task automatic idle(input logic [15:0] pc);
        drive(pc, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0);
    endtask

    task automatic expect_out(input string name, input logic tk, input logic [15:0] tg);
        #1;
        check({name, "_taken"}, {31'd0, predicted_taken}, {31'd0, tk});
        check({name, "_target"}, {16'd0, predicted_target}, {16'd0, tg});
    endtask

    initial begin
        model_reset();
        cmp_en = 1'b1;

        // reset state
        idle(16'h0010);
        expect_out("reset", 1'b0, 16'h0012);
        tick(); tick();
        rst_n = 1'b1;
        tick();
        expect_out("post_reset", 1'b0, 16'h0012);

        // first training, same-cycle read sees old contents
        drive(16'h0010, 16'h0010, 1'b1, 1'b1, 1'b1, 16'h0040);
        expect_out("no_bypass", 1'b0, 16'h0012);
        tick();
        idle(16'h0010);
        expect_out("trained", 1'b1, 16'h0040);

        // saturate to ST then walk down
        for (int k = 0; k < 3; k++) begin
            drive(16'h0010, 16'h0010, 1'b1, 1'b1, 1'b0, 16'h0);
            tick();
        end
        drive(16'h0010, 16'h0010, 1'b1, 1'b0, 1'b0, 16'h0);
        tick();
        idle(16'h0010);
        expect_out("one_nt", 1'b1, 16'h0040);
        drive(16'h0010, 16'h0010, 1'b1, 1'b0, 1'b0, 16'h0);
        tick();
        idle(16'h0010);
        expect_out("two_nt", 1'b0, 16'h0040);

        // aliasing: 0x0030 shares index 0 with 0x0010
        idle(16'h0030);
        expect_out("alias_miss", 1'b0, 16'h0032);
        drive(16'h0030, 16'h0030, 1'b1, 1'b1, 1'b1, 16'h0100);
        tick();
        idle(16'h0030);
        expect_out("alias_hit", 1'b1, 16'h0100);
        idle(16'h0010);
        expect_out("alias_evict", 1'b0, 16'h0012);

        // asynchronous reset between edges, strobes during reset ignored
        idle(16'h0030);
        #1;
        rst_n = 1'b0;
        expect_out("async_rst", 1'b0, 16'h0032);
        drive(16'h0030, 16'h0030, 1'b1, 1'b1, 1'b1, 16'h0200);
        tick(); tick();
        idle(16'h0030);
        #1;
        rst_n = 1'b1;
        expect_out("rst_ignores_upd", 1'b0, 16'h0032);
        tick();

        // wraparound of fall-through target
        idle(16'hFFFE);
        expect_out("wrap", 1'b0, 16'h0000);
        tick();

        // randomized traffic, checked every cycle by the compare process
        for (int c = 0; c < 600; c++) begin
            logic [15:0] p, u;
            p = 16'(($urandom_range(0, 3) << 4) | ($urandom_range(0, 7) << 1) | $urandom_range(0, 1));
            u = 16'(($urandom_range(0, 3) << 4) | ($urandom_range(0, 7) << 1) | $urandom_range(0, 1));
            if ($urandom_range(0, 9) == 0) p = 16'($urandom);
            if ($urandom_range(0, 3) == 0) u = p;
            drive(p, u, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 3) == 0), 16'($urandom));
            if (c % 150 == 149) begin
                #1;
                rst_n = 1'b0;
                #2;
                rst_n = 1'b1;
            end
            tick();
        end

        idle(16'h0000);
        tick();
        cmp_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
